mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the CPU control FSM's MemRead/MemWrite strobes.
- Holds a single-port byte-wide unified instruction/data store.
- Accepts one read or write per transaction, inserts a configurable number of wait states, then returns a one-cycle ready pulse with registered read data.
- The CPU control FSM stalls on mem_ready.

Parameters:
- ADDR_W, 8, address width; depth is 2**ADDR_W bytes.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  read request strobe from the control FSM.
- mem_write  input  1  write request strobe from the control FSM.
- addr  input  ADDR_W  byte address, sampled at accept.
- wdata  input  DATA_W  write data, sampled at accept.
- rdata  output  DATA_W  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high from accept until mem_ready is high.
- proto_err  output  1  sticky protocol-violation flag (PROTO_CHECK_EN only).

Behaviour:
- Reset values: state IDLE; rdata 0; mem_ready 0; busy 0; proto_err 0; wait counter 0. Storage contents are not reset.
- States and transitions:
  - IDLE -> WAIT on accept when WAIT_CYCLES > 0; IDLE -> RESP on accept when WAIT_CYCLES = 0.
  - WAIT counts down from WAIT_CYCLES; WAIT -> RESP when the count reaches 1.
  - RESP -> IDLE unconditionally.
- Accept: in IDLE, (mem_read | mem_write) high at a rising edge. addr, wdata and the operation type are captured into registers. busy goes high on that edge.
- Latency: mem_ready is high exactly WAIT_CYCLES+1 cycles after the accept edge, for one cycle (the RESP state). busy is high from the accept edge through the RESP cycle inclusive, and low in IDLE.
- Write: committed to storage on the edge that enters RESP, using the captured addr/wdata. rdata is unchanged by writes.
- Read: storage at the captured addr is loaded into rdata on the edge entering RESP. rdata stays valid while mem_ready is high and holds until the next completed read.
- Simultaneous mem_read & mem_write at accept: treated as a write (write priority); no rdata update.
- While busy, strobe, addr and wdata changes are ignored; the captured values are used.
- A strobe still high in the IDLE cycle after RESP starts a new transaction. The master must drop its strobe in the mem_ready cycle to avoid a repeat.
- Address wrap: addr is exactly ADDR_W bits; there is no out-of-range case.
- Reset mid-transaction: the state returns to IDLE immediately. A write not yet committed (still in WAIT) is dropped and storage is unchanged. mem_ready deasserts at once.

Optional Feature:
- Macro: MEM_RESPONDER_PROTO_CHECK_EN.
- With the macro: proto_err is set, and held until rst, on any of:
  - mem_read & mem_write at accept;
  - addr or wdata differing from the captured value while in WAIT with a strobe high;
  - both strobes low during WAIT (request dropped early).
- Data-path behaviour is identical with and without the macro.
- Without the macro: proto_err is tied to 0 and the checker logic is absent.

Decomposition:
- Package mem_pkg:
  - state encoding constants IDLE, WAIT, RESP (2-bit);
  - default ADDR_W / DATA_W constants;
  - wait counter width, 4 bits.
- Sub-module mem_array_sp: single-port storage with synchronous write and synchronous registered read, DEPTH x DATA_W.
- The responder FSM, capture registers, counter and checker stay in mem_responder.

Test Plan:
- Reset: assert rst mid-cycle -> rdata=0x00, mem_ready=0, busy=0, proto_err=0 asynchronously, before the next edge.
- WAIT_CYCLES=2: write 0xA5 to 0x10 -> mem_ready high exactly 3 cycles after accept, busy high 3 cycles. Then read 0x10 -> rdata=0xA5 in the mem_ready cycle.
- Back-to-back: write 0x01 to 0xFF, strobe dropped on ready, read 0xFF in the next IDLE cycle -> rdata=0x01. Read of 0x00 is unaffected (no wrap aliasing).
- Simultaneous: mem_read=mem_write=1, addr 0x20, wdata 0x77 -> storage[0x20]=0x77 and rdata keeps its prior value. proto_err=1 with the macro, 0 without.
- Reset during WAIT of a write of 0x55 to 0x30 (prior content 0x11) -> after release, read 0x30 returns 0x11.
- addr changed from 0x40 to 0x41 during WAIT with mem_read held (storage[0x40]=0x9C, storage[0x41]=0x00) -> rdata=0x9C. proto_err=1 with the macro.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default bus widths and the wait-state counter type.
package mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Default address and data widths
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Wait-state counter width; covers WAIT_CYCLES values 0..15
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port byte-wide storage with a synchronous write and a
// registered synchronous read. Only the read register is reset;
// the storage contents are left as they are.
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] storage [DEPTH];

    // Commit a write into storage when the port is enabled for writing
    always_ff @(posedge clk) begin
        if (en && we) begin
            storage[addr] <= wdata;
        end
    end

    // Load the read register on an enabled read; it holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= storage[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU control FSM's read/write strobes.
// Accepts one request in IDLE, waits WAIT_CYCLES cycles, then pulses
// mem_ready for one cycle with the registered read data.
// Optional protocol checker enabled by defining MEM_RESPONDER_PROTO_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              proto_err
);

    state_t            state;
    state_t            state_next;
    cnt_t              wait_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_write;
    logic              accept;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              op_write;
    logic              mem_en;

    assign accept = (state == IDLE) && (mem_read || mem_write);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == cnt_t'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        mem_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            WAIT: busy = 1'b1;
            RESP: begin
                busy      = 1'b1;
                mem_ready = 1'b1;
            end
            default: begin
                mem_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Wait-state counter: loaded at accept, counts down in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= cnt_t'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - cnt_t'(1);
        end
    end

    // Capture the request at accept so later bus changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
        end else if (accept) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_write <= mem_write;
        end
    end

    // With zero wait states RESP is entered on the accept edge itself,
    // so the live bus is used then; otherwise the captured request is used.
    // mem_write alone decides the operation, giving writes priority.
    always_comb begin
        op_addr  = cap_addr;
        op_wdata = cap_wdata;
        op_write = cap_write;
        if (state == IDLE) begin
            op_addr  = addr;
            op_wdata = wdata;
            op_write = mem_write;
        end
    end

    // The storage port fires only on the edge entering RESP, and never
    // while reset is held, so a dropped transaction cannot commit.
    assign mem_en = (state_next == RESP) && !rst;

    mem_array_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (op_write),
        .addr  (op_addr),
        .wdata (op_wdata),
        .rdata (rdata)
    );

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    logic proto_viol;
    logic proto_err_q;

    // Flag a master that asks for both operations, changes the bus
    // mid-transaction, or abandons the request before the response
    always_comb begin
        proto_viol = 1'b0;
        if (accept && mem_read && mem_write) begin
            proto_viol = 1'b1;
        end
        if ((state == WAIT) && (mem_read || mem_write) &&
            ((addr != cap_addr) || (wdata != cap_wdata))) begin
            proto_viol = 1'b1;
        end
        if ((state == WAIT) && !mem_read && !mem_write) begin
            proto_viol = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (proto_viol) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
